traffic_sig_controller: RTL and testbench

Highway/country-road intersection signal controller. The highway holds green by default. When a car is detected on the country road, the controller sequences through yellow and all-red to give the country road green. It returns to highway green once the country road is clear. It is a single-clock Moore FSM with a programmable cycle-count timer for the yellow and all-red intervals.

---
 rtl/traffic_sig_controller.sv | 106 ++++++++++
 tb/tb_traffic_sig_controller.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/traffic_sig_controller.sv
// Highway / country-road intersection signal controller.
// Moore FSM: the highway holds green until a car waits on the country road.
// The controller then steps through highway yellow and all-red to country green.
// It returns through country yellow once the country road is clear.
// The yellow and all-red intervals are counted by a down-timer.
module traffic_sig_controller #(
  parameter int unsigned Y2RDELAY = 3,
  parameter int unsigned R2GDELAY = 2,
  parameter int unsigned TIMER_W  = 8
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       X,
  output logic [1:0] hwy,
  output logic [1:0] cntry
);

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  // Timer reload values: a state lasting N cycles loads N-1 and leaves on zero.
  localparam logic [TIMER_W-1:0] Y2R_LOAD = TIMER_W'(Y2RDELAY - 1);
  localparam logic [TIMER_W-1:0] R2G_LOAD = TIMER_W'(R2GDELAY - 1);
  localparam logic [TIMER_W-1:0] TMR_ONE  = TIMER_W'(1);

  typedef enum logic [2:0] {
    S0 = 3'd0,  // highway green, country red
    S1 = 3'd1,  // highway yellow
    S2 = 3'd2,  // all red
    S3 = 3'd3,  // country green
    S4 = 3'd4   // country yellow
  } state_t;

  state_t               r_state;
  logic [TIMER_W-1:0]   r_timer;
  logic                 w_tmr_done;

  assign w_tmr_done = (r_timer == '0);

  // State and timer update; reset dominates, and illegal encodings fall back to S0.
  always_ff @(posedge clock) begin
    if (!clear) begin
      r_state <= S0;
      r_timer <= '0;
    end else begin
      case (r_state)
        S0: begin
          if (X) begin
            r_state <= S1;
            r_timer <= Y2R_LOAD;
          end
        end
        S1: begin
          if (w_tmr_done) begin
            r_state <= S2;
            r_timer <= R2G_LOAD;
          end else begin
            r_timer <= r_timer - TMR_ONE;
          end
        end
        S2: begin
          if (w_tmr_done) begin
            r_state <= S3;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer - TMR_ONE;
          end
        end
        S3: begin
          if (!X) begin
            r_state <= S4;
            r_timer <= Y2R_LOAD;
          end
        end
        S4: begin
          if (w_tmr_done) begin
            r_state <= S0;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer - TMR_ONE;
          end
        end
        default: begin
          r_state <= S0;
          r_timer <= '0;
        end
      endcase
    end
  end

  // Signal decode from the registered state only; X never reaches the lamps directly.
  always_comb begin
    hwy   = GREEN;
    cntry = RED;
    case (r_state)
      S0: begin hwy = GREEN;  cntry = RED;    end
      S1: begin hwy = YELLOW; cntry = RED;    end
      S2: begin hwy = RED;    cntry = RED;    end
      S3: begin hwy = RED;    cntry = GREEN;  end
      S4: begin hwy = RED;    cntry = YELLOW; end
      default: begin hwy = GREEN; cntry = RED; end
    endcase
  end

endmodule

// File: tb/tb_traffic_sig_controller.sv
// Directed bench for traffic_sig_controller.
// DUT A uses the default delays (3/2) and DUT B uses one-cycle delays (1/1).
// Inputs change on the falling edge, and outputs are checked on that same falling edge.
module tb_traffic_sig_controller;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] G = 2'b10;

  logic       clock = 1'b0;
  logic       clear;
  logic       x_a, x_b;
  logic [1:0] hwy_a, cntry_a, hwy_b, cntry_b;

  int vectors     = 0;
  int miscompares = 0;
  bit inv_en      = 1'b0;

  always #5 clock = ~clock;

  traffic_sig_controller #(.Y2RDELAY(3), .R2GDELAY(2), .TIMER_W(8)) u_dut_a (
    .clock (clock),
    .clear (clear),
    .X     (x_a),
    .hwy   (hwy_a),
    .cntry (cntry_a)
  );

  traffic_sig_controller #(.Y2RDELAY(1), .R2GDELAY(1), .TIMER_W(8)) u_dut_b (
    .clock (clock),
    .clear (clear),
    .X     (x_b),
    .hwy   (hwy_b),
    .cntry (cntry_b)
  );

  // Safety invariant on both controllers every cycle after the first reset edge.
  always @(negedge clock) begin
    if (inv_en) begin
      vectors++;
      assert (!((hwy_a !== R) && (cntry_a !== R)) && !((hwy_b !== R) && (cntry_b !== R)))
      else begin
        miscompares++;
        $error("FAIL invariant: a=%b/%b b=%b/%b required one side RED", hwy_a, cntry_a, hwy_b, cntry_b);
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk_a(input string tag, input logic [1:0] eh, input logic [1:0] ec);
    vectors++;
    assert ({hwy_a, cntry_a} === {eh, ec})
    else begin
      miscompares++;
      $error("FAIL %s: hwy/cntry=%b/%b expected %b/%b", tag, hwy_a, cntry_a, eh, ec);
    end
  endtask

  task automatic chk_b(input string tag, input logic [1:0] eh, input logic [1:0] ec);
    vectors++;
    assert ({hwy_b, cntry_b} === {eh, ec})
    else begin
      miscompares++;
      $error("FAIL %s: hwy/cntry=%b/%b expected %b/%b", tag, hwy_b, cntry_b, eh, ec);
    end
  endtask

  task automatic exp_a(input string tag, input int n, input logic [1:0] eh, input logic [1:0] ec);
    for (int i = 0; i < n; i++) begin
      tick();
      chk_a(tag, eh, ec);
    end
  endtask

  task automatic exp_b(input string tag, input int n, input logic [1:0] eh, input logic [1:0] ec);
    for (int i = 0; i < n; i++) begin
      tick();
      chk_b(tag, eh, ec);
    end
  endtask

  // Single-cycle request on DUT A: the whole cycle runs with one cycle of country green.
  task automatic pulse_a(input string tag);
    x_a = 1'b1;
    tick();
    chk_a({tag, "_yel"}, Y, R);
    x_a = 1'b0;
    exp_a({tag, "_yel"}, 2, Y, R);
    exp_a({tag, "_red"}, 2, R, R);
    exp_a({tag, "_cgrn"}, 1, R, G);
    exp_a({tag, "_cyel"}, 3, R, Y);
    exp_a({tag, "_hgrn"}, 3, G, R);
  endtask

  initial begin
    clear = 1'b0;
    x_a   = 1'b0;
    x_b   = 1'b0;

    // Test 1: reset held, then idle highway green.
    exp_a("t1_rst", 5, G, R);
    chk_b("t1_rst_b", G, R);
    inv_en = 1'b1;
    clear  = 1'b1;
    exp_a("t1_idle", 14, G, R);

    // Test 2/3: request for 10 cycles, then release.
    x_a = 1'b1;
    exp_a("t2_yel", 3, Y, R);
    exp_a("t2_red", 2, R, R);
    exp_a("t2_cgrn", 5, R, G);
    x_a = 1'b0;
    exp_a("t3_cyel", 3, R, Y);
    exp_a("t3_hgrn", 4, G, R);

    // Test 4: single-cycle request.
    pulse_a("t4");

    // Test 5a: reset during all-red, with X high to show it is ignored under reset.
    x_a = 1'b1;
    tick();
    chk_a("t5a_yel", Y, R);
    x_a = 1'b0;
    exp_a("t5a_yel", 2, Y, R);
    exp_a("t5a_red", 1, R, R);
    clear = 1'b0;
    x_a   = 1'b1;
    exp_a("t5a_rst", 1, G, R);
    clear = 1'b1;
    x_a   = 1'b0;
    exp_a("t5a_hgrn", 2, G, R);
    pulse_a("t5a_again");

    // Test 5b: reset in the middle of country yellow.
    x_a = 1'b1;
    tick();
    chk_a("t5b_yel", Y, R);
    x_a = 1'b0;
    exp_a("t5b_yel", 2, Y, R);
    exp_a("t5b_red", 2, R, R);
    exp_a("t5b_cgrn", 1, R, G);
    exp_a("t5b_cyel", 2, R, Y);
    clear = 1'b0;
    exp_a("t5b_rst", 1, G, R);
    clear = 1'b1;
    exp_a("t5b_hgrn", 2, G, R);
    pulse_a("t5b_again");

    // Test 6: one-cycle yellow/all-red on DUT B, three times, 20 cycles apart.
    for (int rep = 0; rep < 3; rep++) begin
      x_b = 1'b1;
      exp_b("t6_yel", 1, Y, R);
      exp_b("t6_red", 1, R, R);
      exp_b("t6_cgrn", 8, R, G);
      x_b = 1'b0;
      exp_b("t6_cyel", 1, R, Y);
      exp_b("t6_hgrn", 9, G, R);
    end
    chk_a("t6_a_idle", G, R);

    inv_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
